ex_mem_skid: RTL

- Pipeline boundary between the 32-bit ALU (execute) and data memory stage; captures ALU result z, zero flag, store operand and control bits.
- Two-entry skid buffer with valid/ready on both sides, so memory back-pressure never forces a combinational ready path back into execute.
- Adds a misalignment tag per entry, a synchronous flush and a saturating stall counter.

---
 rtl/ex_mem_skid.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/ex_mem_skid.sv
// ex_mem_skid: EX/MEM pipeline boundary built as a two-entry skid buffer.
//
// It captures the ALU result, zero flag, store operand and control bits from
// execute and presents them to the data memory stage. in_ready is a flop, so
// out_ready never reaches execute through a combinational path. Each entry
// carries a misalignment tag computed on entry. A flush empties the buffer.
// A saturating counter tracks the number of cycles the memory stage stalls.
//
// Ports:
//   clk, rst_n          rising-edge clock; synchronous active-low reset
//   in_valid/in_ready   upstream handshake (in_ready is registered)
//   in_z, in_zero, in_b, in_rd, in_mem_rd, in_mem_wr, in_reg_wr
//                       incoming entry fields
//   flush               discards all held entries
//   out_valid/out_ready downstream handshake for the head entry
//   out_*               head entry fields; out_misalign is the stored tag
//   stall_cnt           saturating count of cycles with out_valid & ~out_ready
//
// Optional feature: define EX_MEM_FWD_EN to add fwd_valid/fwd_rd/fwd_z. These
// are combinational from the head entry and feed the execute operand muxes.
module ex_mem_skid #(
  parameter int unsigned DW = 32,
  parameter int unsigned RW = 5,
  parameter int unsigned CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_z,
  input  logic          in_zero,
  input  logic [DW-1:0] in_b,
  input  logic [RW-1:0] in_rd,
  input  logic          in_mem_rd,
  input  logic          in_mem_wr,
  input  logic          in_reg_wr,
  input  logic          flush,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_z,
  output logic          out_zero,
  output logic [DW-1:0] out_b,
  output logic [RW-1:0] out_rd,
  output logic          out_mem_rd,
  output logic          out_mem_wr,
  output logic          out_reg_wr,
  output logic          out_misalign,
  output logic [CW-1:0] stall_cnt
`ifdef EX_MEM_FWD_EN
  ,
  output logic          fwd_valid,
  output logic [RW-1:0] fwd_rd,
  output logic [DW-1:0] fwd_z
`endif
);

  typedef struct packed {
    logic [DW-1:0] z;
    logic [DW-1:0] b;
    logic [RW-1:0] rd;
    logic          zero;
    logic          mem_rd;
    logic          mem_wr;
    logic          reg_wr;
    logic          misalign;
  } entry_t;

  // Occupancy: StOne means only the head is valid, StFull means head and skid.
  typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

  state_e          state_q, state_d;
  entry_t          h_q, h_d;
  entry_t          s_q, s_d;
  logic            in_ready_q, in_ready_d;
  logic [CW-1:0]   stall_cnt_q, stall_cnt_d;

  entry_t          in_entry;
  logic            accept;
  logic            drain;

  always_comb begin
    in_entry          = '0;
    in_entry.z        = in_z;
    in_entry.b        = in_b;
    in_entry.rd       = in_rd;
    in_entry.zero     = in_zero;
    in_entry.mem_rd   = in_mem_rd;
    in_entry.mem_wr   = in_mem_wr;
    in_entry.reg_wr   = in_reg_wr;
    in_entry.misalign = (in_mem_rd | in_mem_wr) & (in_z[1:0] != 2'b00);
  end

  assign out_valid = (state_q != StEmpty);
  assign accept    = in_valid & in_ready_q;
  assign drain     = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    s_d     = s_q;
    unique case (state_q)
      StEmpty: begin
        if (accept) begin
          h_d     = in_entry;
          state_d = StOne;
        end
      end
      StOne: begin
        if (accept && drain) begin
          h_d = in_entry;
        end else if (accept) begin
          s_d     = in_entry;
          state_d = StFull;
        end else if (drain) begin
          state_d = StEmpty;
        end
      end
      StFull: begin
        // in_ready is low here, so no accept can coincide with the drain.
        if (drain) begin
          h_d     = s_q;
          state_d = StOne;
        end
      end
      default: state_d = StEmpty;
    endcase
    // Data of flushed entries is left stale; only the occupancy is cleared.
    if (flush) begin
      state_d = StEmpty;
    end
    in_ready_d = (state_d != StFull);
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_valid && !out_ready && (stall_cnt_q != {CW{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StEmpty;
      h_q         <= '0;
      s_q         <= '0;
      in_ready_q  <= 1'b1;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      h_q         <= h_d;
      s_q         <= s_d;
      in_ready_q  <= in_ready_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign out_z        = h_q.z;
  assign out_zero     = h_q.zero;
  assign out_b        = h_q.b;
  assign out_rd       = h_q.rd;
  assign out_mem_rd   = h_q.mem_rd;
  assign out_mem_wr   = h_q.mem_wr;
  assign out_reg_wr   = h_q.reg_wr;
  assign out_misalign = h_q.misalign;
  assign stall_cnt    = stall_cnt_q;

`ifdef EX_MEM_FWD_EN
  // Loads are excluded because their result is not known until after memory.
  assign fwd_valid = out_valid & h_q.reg_wr & ~h_q.mem_rd & (h_q.rd != '0);
  assign fwd_rd    = h_q.rd;
  assign fwd_z     = h_q.z;
`endif

endmodule
